// File: rtl/seq_shift_left.sv
// Multi-cycle logical left shifter: dataA << dataB[SHAMT_W-1:0] under a start/busy/done handshake.
// Optional SHIFT_STEP4_EN: take 4-bit steps while at least 4 positions remain (shorter latency, same result).
module seq_shift_left #(
  parameter int         WIDTH   = 32,
  parameter int         SHAMT_W = 5,
  parameter logic [5:0] SLL     = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   acc, acc_nx;
  logic [SHAMT_W-1:0] count, count_nx;
  logic               load_out;
  logic               accept;

  // Only the low SHAMT_W bits of dataB form the shift amount.
  logic unused_b;
  assign unused_b = ^dataB[WIDTH-1:SHAMT_W];

  assign accept = start && (Signal == SLL);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    load_out = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nx   = dataA;
          count_nx = dataB[SHAMT_W-1:0];
          if (dataB[SHAMT_W-1:0] == '0) begin
            state_nx = DONE;
            load_out = 1'b1;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
`ifdef SHIFT_STEP4_EN
        if (count >= SHAMT_W'(4)) begin
          acc_nx   = acc << 4;
          count_nx = count - SHAMT_W'(4);
        end else begin
          acc_nx   = acc << 1;
          count_nx = count - SHAMT_W'(1);
        end
`else
        acc_nx   = acc << 1;
        count_nx = count - SHAMT_W'(1);
`endif
        // dataOut captures the final value on the same edge that enters DONE.
        if (count_nx == '0) begin
          state_nx = DONE;
          load_out = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      count   <= '0;
      dataOut <= '0;
    end else begin
      acc   <= acc_nx;
      count <= count_nx;
      if (load_out) dataOut <= acc_nx;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shift_left.sv
// Bench for seq_shift_left: per-cycle comparison against an operation-level model plus directed literal checks.
module tb_seq_shift_left;

  localparam logic [5:0] SLL = 6'b000000;
`ifdef SHIFT_STEP4_EN
  localparam int T2_LAT = 11;
  localparam int T5_LAT = 3;
`else
  localparam int T2_LAT = 32;
  localparam int T5_LAT = 9;
`endif

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic [5:0]  Signal = SLL;
  logic [31:0] dataA  = '0;
  logic [31:0] dataB  = '0;
  logic [31:0] dataOut;
  logic        busy, done;

  int compared   = 0;
  int mismatched = 0;

  seq_shift_left #(.WIDTH(32), .SHAMT_W(5), .SLL(SLL)) dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .dataOut(dataOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles from the accepting edge to the done cycle, for shift amount k.
  function automatic int lat_of(input int k);
`ifdef SHIFT_STEP4_EN
    return k / 4 + k % 4 + 1;
`else
    return k + 1;
`endif
  endfunction

  // Operation-level model: remaining busy cycles (done is the last), pending result, visible result.
  int          m_left = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_out  = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_out  = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1) m_out = m_res;
    end else if (start && Signal == SLL) begin
      m_res  = dataA << dataB[4:0];
      m_left = lat_of(int'(dataB[4:0]));
      if (m_left == 1) m_out = m_res;
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'b0, busy}, {31'b0, m_left > 0});
    chk("cyc_done", {31'b0, done}, {31'b0, m_left == 1});
    chk("cyc_dataOut", dataOut, m_out);
  end

  // Issue one request; returns the done cycle (-1 if none within the budget) and dataOut there.
  // Optionally pulses a second request at cycle intr, or holds start (hold) for the whole window.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                       input bit hold, input int intr, input logic [31:0] ia, input logic [31:0] ib,
                       output int lat, output logic [31:0] res);
    @(negedge clk);
    dataA = a; dataB = b; Signal = sig; start = 1'b1;
    lat = -1;
    res = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      start = hold || (intr == n);
      if (intr == n) begin
        dataA = ia; dataB = ib; Signal = SLL;
      end else if (n == 1 && !hold) begin
        dataA = $urandom; dataB = $urandom;
      end
      if (done && lat < 0) begin
        lat = n;
        res = dataOut;
      end
      if (lat > 0 && n > intr) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] res, prev;

    // Reset held with start asserted: nothing may happen.
    start = 1'b1; Signal = SLL; dataA = 32'hDEADBEEF; dataB = 32'd5;
    repeat (2) begin
      @(negedge clk);
      chk("rst_dataOut", dataOut, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
    end
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);

    // Maximum shift amount.
    do_op(32'h1, 32'd31, SLL, 0, 0, 0, 0, lat, res);
    chk("t2_lat", 32'(lat), 32'(T2_LAT));
    chk("t2_res", res, 32'h8000_0000);
    chk("t2_model", m_out, 32'h8000_0000);

    // Zero shift, then upper dataB bits ignored.
    do_op(32'hDEADBEEF, 32'h0, SLL, 0, 0, 0, 0, lat, res);
    chk("t3a_lat", 32'(lat), 32'd1);
    chk("t3a_res", res, 32'hDEADBEEF);
    do_op(32'h0000000F, 32'h24, SLL, 0, 0, 0, 0, lat, res);
    chk("t3b_lat", 32'(lat), 32'(lat_of(4)));
    chk("t3b_res", res, 32'h0000_00F0);
    chk("t3b_model", m_out, 32'h0000_00F0);

    // Foreign function code held with start: ignored.
    prev = dataOut;
    do_op(32'h5555AAAA, 32'd3, 6'b000010, 1, 0, 0, 0, lat, res);
    chk("t4_lat", 32'(lat), 32'hFFFF_FFFF);
    chk("t4_hold", dataOut, prev);

    // Request while busy is lost.
    do_op(32'h12345678, 32'd8, SLL, 0, 3, 32'hFFFFFFFF, 32'd1, lat, res);
    chk("t5_lat", 32'(lat), 32'(T5_LAT));
    chk("t5_res", res, 32'h3456_7800);
    repeat (3) @(negedge clk);
    chk("t5_idle", {31'b0, busy}, 32'h0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    dataA = 32'hFFFFFFFF; dataB = 32'd20; Signal = SLL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_busy", {31'b0, busy}, 32'h0);
    chk("t6_async_done", {31'b0, done}, 32'h0);
    chk("t6_async_dataOut", dataOut, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_op(32'h1, 32'd3, SLL, 0, 0, 0, 0, lat, res);
    chk("t6_lat", 32'(lat), 32'd4);
    chk("t6_res", res, 32'h0000_0008);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic [5:0]  sig;
      int          intr;
      a    = $urandom;
      b    = $urandom;
      sig  = ($urandom_range(3) == 0) ? 6'($urandom_range(1, 63)) : SLL;
      intr = ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0;
      prev = dataOut;
      do_op(a, b, sig, 0, intr, $urandom, $urandom, lat, res);
      if (sig == SLL) begin
        if (intr == 0 || intr < lat_of(int'(b[4:0]))) begin
          chk("rnd_lat", 32'(lat), 32'(lat_of(int'(b[4:0]))));
          chk("rnd_res", res, a << b[4:0]);
        end
      end else if (intr == 0) begin
        chk("rnd_ign_lat", 32'(lat), 32'hFFFF_FFFF);
        chk("rnd_ign_out", dataOut, prev);
      end
      repeat (40) begin
        if (!busy) break;
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
